duty_cycle_meter_mc: RTL and testbench
======================================

DUTY_CYCLE_METER_MC -- requirements
Module: duty_cycle_meter_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent input channels (1..16).
REQ-002 Parameter CNT_W, default 32: width of every counter and result field.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth per channel (2..4).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 sys_clk  input  1  sole clock; all state on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  1 = run back-to-back gate windows; 0 = stop after current window.
REQ-008 gate_len  input  CNT_W  window length in sys_clk cycles; sampled at window start.
REQ-009 sig_in  input  NUM_CH  asynchronous measured signals, bit i = channel i.
REQ-010 res_high  output  NUM_CH*CNT_W  per-channel high-cycle counts, channel i at [i*CNT_W +: CNT_W].
REQ-011 res_low  output  NUM_CH*CNT_W  per-channel low-cycle counts, same packing.
REQ-012 res_sat  output  NUM_CH  channel counter saturated during the published window.
REQ-013 res_valid  output  1  result set available.
REQ-014 res_ready  input  1  consumer accepts result when res_valid && res_ready.
REQ-015 res_overrun  output  1  sticky: a result was overwritten before acceptance.
REQ-016 busy  output  1  high while a window is in progress.

Function
REQ-017 FSM states IDLE, MEASURE, PUBLISH; IDLE->MEASURE when enable=1.
REQ-018 On entering MEASURE, the window counter loads gate_len; gate_len=0 is treated as 1.
REQ-019 In MEASURE, each cycle increments res-side high_cnt[i] if the synchronised sig_in[i]=1, else low_cnt[i].
REQ-020 Counters saturate at all-ones; saturation sets the channel's sat flag for that window.
REQ-021 high_cnt[i]+low_cnt[i] equals the effective gate_len exactly when no saturation occurred.
REQ-022 MEASURE->PUBLISH after the last window cycle; PUBLISH lasts exactly one cycle.
REQ-023 In PUBLISH, counters and sat flags copy to res_*; res_valid=1 from the next cycle; working counters and sat flags clear.
REQ-024 PUBLISH->MEASURE if enable=1, else IDLE; no window cycle is lost between back-to-back windows.
REQ-025 res_valid clears the cycle after res_valid && res_ready; res_* hold stable while res_valid=1 and not accepted.
REQ-026 If PUBLISH occurs while res_valid=1 and res_ready=0, results are overwritten, res_valid stays 1, res_overrun sets.
REQ-027 Simultaneous PUBLISH and acceptance: new results load, res_valid stays 1, no overrun.
REQ-028 res_overrun clears only on rst.
REQ-029 enable deasserted mid-window: the window completes and publishes, then IDLE.
REQ-030 busy=1 in MEASURE and PUBLISH.

Reset
REQ-031 rst asserted forces IDLE, clears all counters, synchronisers, sat flags, res_high, res_low, res_sat, res_valid, res_overrun, busy to 0, asynchronously, mid-window included.
REQ-032 First window starts no earlier than the first rising edge after rst deasserts with enable=1.

Configuration
REQ-033 Macro DUTY_METER_EDGE_CNT_EN defined: adds output res_edges (NUM_CH*CNT_W), per-channel count of synchronised rising edges within the window, saturating, published and held like res_high.
REQ-034 Macro undefined: no res_edges port and no edge-counting logic.

Structure
REQ-035 Package duty_meter_pkg holds the FSM state enum type and the SYNC_STAGES bounds constants.
REQ-036 Sub-module duty_meter_chan holds one channel's synchroniser, high/low (and optional edge) counters and sat flag; instantiated NUM_CH times by generate.

Verification
REQ-037 NUM_CH=4, gate_len=100, sig_in[0]=1 constant, others 0 -> res_high[0]=100, res_low[0]=0, res_low[1..3]=100, res_sat=0.
REQ-038 gate_len=1000, channel 2 square wave 30 high/70 low cycles -> res_high[2]=300, res_low[2]=700 (+/-1 for phase).
REQ-039 CNT_W=8, gate_len=255, sig_in[1]=1 constant, window ending with sat -> res_high[1]=255; gate_len=0 -> effective length 1.
REQ-040 res_ready=0 across two windows -> res_overrun=1, res_* equal second window; rst clears it.
REQ-041 rst asserted at cycle 50 of a 100-cycle window -> all outputs 0 immediately; next window after release reports full 100 counts.
REQ-042 With DUTY_METER_EDGE_CNT_EN, 10 pulses on channel 3 within window -> res_edges[3]=10.

Source files
------------

// File: rtl/duty_meter_pkg.sv
// Shared types and constants for the duty-cycle meter: FSM state encoding,
// synchroniser depth bounds and a helper that keeps the depth in range.
package duty_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    PUBLISH = 2'd2
  } meter_state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Out-of-range depths are pulled back into the supported window.
  function automatic int unsigned clamp_sync(input int unsigned n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/duty_meter_chan.sv
// One measurement channel: input synchroniser, saturating high/low counters
// and the window's sat flag. Optional rising-edge counter when
// DUTY_METER_EDGE_CNT_EN is defined.
module duty_meter_chan
  import duty_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             count_en,
  input  logic             clear,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
`ifdef DUTY_METER_EDGE_CNT_EN
  output logic [CNT_W-1:0] edge_cnt,
`endif
  output logic             sat
);

  localparam int unsigned DEPTH = clamp_sync(SYNC_STAGES);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0] sync_q;
  logic             sig_s;
  logic [CNT_W-1:0] high_nxt;
  logic [CNT_W-1:0] low_nxt;
  logic             sat_nxt;

  assign sig_s = sync_q[DEPTH-1];

  // Multi-flop synchroniser for the asynchronous input.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[DEPTH-2:0], sig_in};
  end

`ifdef DUTY_METER_EDGE_CNT_EN
  logic             sig_prev;
  logic [CNT_W-1:0] edge_nxt;

  // Previous synchronised level, for rising-edge detection.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) sig_prev <= 1'b0;
    else     sig_prev <= sig_s;
  end
`endif

  // Saturating next-count values; a counter reaching all-ones flags the window.
  always_comb begin
    high_nxt = high_cnt;
    low_nxt  = low_cnt;
    sat_nxt  = sat;
`ifdef DUTY_METER_EDGE_CNT_EN
    edge_nxt = edge_cnt;
`endif
    if (count_en) begin
      if (sig_s) begin
        if (high_cnt != '1) high_nxt = high_cnt + ONE;
      end else begin
        if (low_cnt != '1) low_nxt = low_cnt + ONE;
      end
`ifdef DUTY_METER_EDGE_CNT_EN
      if (sig_s && !sig_prev && (edge_cnt != '1)) edge_nxt = edge_cnt + ONE;
      sat_nxt = sat | (&high_nxt) | (&low_nxt) | (&edge_nxt);
`else
      sat_nxt = sat | (&high_nxt) | (&low_nxt);
`endif
    end
  end

  // Working counters: clear on publish, advance while measuring.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      high_cnt <= '0;
      low_cnt  <= '0;
      sat      <= 1'b0;
    end else if (clear) begin
      high_cnt <= '0;
      low_cnt  <= '0;
      sat      <= 1'b0;
    end else begin
      high_cnt <= high_nxt;
      low_cnt  <= low_nxt;
      sat      <= sat_nxt;
    end
  end

`ifdef DUTY_METER_EDGE_CNT_EN
  // Rising-edge counter, cleared with the other working counters.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)        edge_cnt <= '0;
    else if (clear) edge_cnt <= '0;
    else            edge_cnt <= edge_nxt;
  end
`endif

endmodule

// File: rtl/duty_cycle_meter_mc.sv
// Multi-channel duty-cycle meter: gated measurement windows, per-channel
// high/low counts published through a valid/ready result register with
// sticky overrun. Optional feature macro: DUTY_METER_EDGE_CNT_EN (adds res_edges).
module duty_cycle_meter_mc
  import duty_meter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        gate_len,
  input  logic [NUM_CH-1:0]       sig_in,
  output logic [NUM_CH*CNT_W-1:0] res_high,
  output logic [NUM_CH*CNT_W-1:0] res_low,
`ifdef DUTY_METER_EDGE_CNT_EN
  output logic [NUM_CH*CNT_W-1:0] res_edges,
`endif
  output logic [NUM_CH-1:0]       res_sat,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_overrun,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] win_q;
  logic             load_win;
  logic             count_en;
  logic             publish;

  logic [CNT_W-1:0]  high_w [NUM_CH];
  logic [CNT_W-1:0]  low_w  [NUM_CH];
  logic [NUM_CH-1:0] sat_w;
`ifdef DUTY_METER_EDGE_CNT_EN
  logic [CNT_W-1:0]  edge_w [NUM_CH];
`endif

  // FSM state register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and per-state strobes; the window reloads straight out of
  // PUBLISH so back-to-back windows lose no cycle.
  always_comb begin
    state_d  = state_q;
    load_win = 1'b0;
    count_en = 1'b0;
    publish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = MEASURE;
          load_win = 1'b1;
        end
      end
      MEASURE: begin
        count_en = 1'b1;
        if (win_q <= ONE) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish = 1'b1;
        if (enable) begin
          state_d  = MEASURE;
          load_win = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window length counter; a zero gate length runs a one-cycle window.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)           win_q <= '0;
    else if (load_win) win_q <= (gate_len == '0) ? ONE : gate_len;
    else if (count_en) win_q <= win_q - ONE;
  end

  assign busy = (state_q != IDLE);

  // Channel instances.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    duty_meter_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .sys_clk (sys_clk),
      .rst     (rst),
      .sig_in  (sig_in[g]),
      .count_en(count_en),
      .clear   (publish),
      .high_cnt(high_w[g]),
      .low_cnt (low_w[g]),
`ifdef DUTY_METER_EDGE_CNT_EN
      .edge_cnt(edge_w[g]),
`endif
      .sat     (sat_w[g])
    );
  end

  // Result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      res_high    <= '0;
      res_low     <= '0;
`ifdef DUTY_METER_EDGE_CNT_EN
      res_edges   <= '0;
`endif
      res_sat     <= '0;
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
    end else if (publish) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        res_high[ch*CNT_W +: CNT_W]  <= high_w[ch];
        res_low[ch*CNT_W +: CNT_W]   <= low_w[ch];
`ifdef DUTY_METER_EDGE_CNT_EN
        res_edges[ch*CNT_W +: CNT_W] <= edge_w[ch];
`endif
      end
      res_sat   <= sat_w;
      res_valid <= 1'b1;
      if (res_valid && !res_ready) res_overrun <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_duty_cycle_meter_mc.sv
// Directed self-checking bench for duty_cycle_meter_mc (32-bit and 8-bit builds).
module tb_duty_cycle_meter_mc;

  logic         sys_clk;
  logic         rst;
  logic         enable, enable8;
  logic [31:0]  gate_len;
  logic [7:0]   gate_len8;
  logic [3:0]   sig_base;
  logic [127:0] res_high, res_low;
  logic [31:0]  res_high8, res_low8;
  logic [3:0]   res_sat, res_sat8;
  logic         res_valid, res_valid8;
  logic         res_ready, res_ready8;
  logic         res_overrun, res_overrun8;
  logic         busy, busy8;
`ifdef DUTY_METER_EDGE_CNT_EN
  logic [127:0] res_edges;
  logic [31:0]  res_edges8;
`endif

  int checks = 0;
  int errors = 0;
  bit ok;

  duty_cycle_meter_mc #(.NUM_CH(4), .CNT_W(32), .SYNC_STAGES(2)) u_dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .enable     (enable),
    .gate_len   (gate_len),
    .sig_in     (sig_base),
    .res_high   (res_high),
    .res_low    (res_low),
`ifdef DUTY_METER_EDGE_CNT_EN
    .res_edges  (res_edges),
`endif
    .res_sat    (res_sat),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_overrun(res_overrun),
    .busy       (busy)
  );

  duty_cycle_meter_mc #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .enable     (enable8),
    .gate_len   (gate_len8),
    .sig_in     (sig_base),
    .res_high   (res_high8),
    .res_low    (res_low8),
`ifdef DUTY_METER_EDGE_CNT_EN
    .res_edges  (res_edges8),
`endif
    .res_sat    (res_sat8),
    .res_valid  (res_valid8),
    .res_ready  (res_ready8),
    .res_overrun(res_overrun8),
    .busy       (busy8)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic logic [31:0] f32(input logic [127:0] v, input int i);
    return v[i*32 +: 32];
  endfunction

  function automatic logic [31:0] f8(input logic [31:0] v, input int i);
    return {24'd0, v[i*8 +: 8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output bit got);
    got = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge sys_clk);
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid8(input int max_cyc, output bit got);
    got = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge sys_clk);
      if (res_valid8) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; enable8 = 1'b0; gate_len = '0; gate_len8 = '0;
    sig_base = '0; res_ready = 1'b0; res_ready8 = 1'b0;
    repeat (3) @(negedge sys_clk);

    // reset state
    chk("rst_valid",   32'(res_valid), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_overrun", 32'(res_overrun), 0);
    chk("rst_sat",     32'(res_sat), 0);
    chk("rst_high0",   f32(res_high, 0), 0);
    chk("rst_low1",    f32(res_low, 1), 0);

    // single 100-cycle window, channel 0 constant high
    sig_base = 4'b0001;
    rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    gate_len = 100; enable = 1'b1;
    @(negedge sys_clk);
    chk("w1_busy", 32'(busy), 1);
    enable = 1'b0;
    wait_valid(200, ok);
    chk("w1_timeout", 32'(ok), 1);
    chk("w1_high0", f32(res_high, 0), 100);
    chk("w1_low0",  f32(res_low, 0), 0);
    chk("w1_high1", f32(res_high, 1), 0);
    chk("w1_low1",  f32(res_low, 1), 100);
    chk("w1_low2",  f32(res_low, 2), 100);
    chk("w1_low3",  f32(res_low, 3), 100);
    chk("w1_sat",   32'(res_sat), 0);
    chk("w1_ovr",   32'(res_overrun), 0);
    chk("w1_idle",  32'(busy), 0);
    repeat (5) @(negedge sys_clk);
    chk("w1_hold_valid", 32'(res_valid), 1);
    chk("w1_hold_high0", f32(res_high, 0), 100);
    res_ready = 1'b1;
    @(negedge sys_clk);
    chk("w1_accept", 32'(res_valid), 0);
    res_ready = 1'b0;

    // back-to-back windows (30 then 20), accept exactly in the second PUBLISH
    gate_len = 30; enable = 1'b1;
    @(negedge sys_clk);
    gate_len = 20;
    wait_valid(100, ok);
    chk("bb_timeout", 32'(ok), 1);
    enable = 1'b0;
    chk("bb_a_high0", f32(res_high, 0), 30);
    repeat (20) @(negedge sys_clk);
    res_ready = 1'b1;
    @(negedge sys_clk);
    res_ready = 1'b0;
    chk("bb_valid", 32'(res_valid), 1);
    chk("bb_ovr",   32'(res_overrun), 0);
    chk("bb_high0", f32(res_high, 0), 20);
    chk("bb_low3",  f32(res_low, 3), 20);
    res_ready = 1'b1;
    @(negedge sys_clk);
    chk("bb_accept", 32'(res_valid), 0);
    res_ready = 1'b0;

    // 1000-cycle window, channel 2 square wave 30 high / 70 low
    gate_len = 1000;
    for (int k = 0; k < 1300; k++) begin
      sig_base = {1'b0, ((k % 100) < 30), 2'b00};
      if (k == 200) enable = 1'b1;
      if (k == 201) enable = 1'b0;
      @(negedge sys_clk);
    end
    chk("sq_valid", 32'(res_valid), 1);
    chk("sq_high2", f32(res_high, 2), 300);
    chk("sq_low2",  f32(res_low, 2), 700);
    chk("sq_low0",  f32(res_low, 0), 1000);
    chk("sq_sat",   32'(res_sat), 0);
    res_ready = 1'b1;
    @(negedge sys_clk);
    res_ready = 1'b0;

    // 8-bit build: 255-cycle window saturates, then gate_len 0 acts as 1
    sig_base = 4'b0010;
    repeat (5) @(negedge sys_clk);
    gate_len8 = 8'd255; enable8 = 1'b1;
    @(negedge sys_clk);
    enable8 = 1'b0;
    wait_valid8(400, ok);
    chk("s8_timeout", 32'(ok), 1);
    chk("s8_high1", f8(res_high8, 1), 255);
    chk("s8_low1",  f8(res_low8, 1), 0);
    chk("s8_low0",  f8(res_low8, 0), 255);
    chk("s8_sat",   32'(res_sat8), 32'hF);
    res_ready8 = 1'b1;
    @(negedge sys_clk);
    res_ready8 = 1'b0;
    gate_len8 = 8'd0; enable8 = 1'b1;
    @(negedge sys_clk);
    enable8 = 1'b0;
    wait_valid8(20, ok);
    chk("z8_timeout", 32'(ok), 1);
    chk("z8_high1", f8(res_high8, 1), 1);
    chk("z8_low1",  f8(res_low8, 1), 0);
    chk("z8_low2",  f8(res_low8, 2), 1);
    chk("z8_sat",   32'(res_sat8), 0);

    // overrun: two windows (100 then 50) without acceptance
    sig_base = 4'b0001;
    repeat (5) @(negedge sys_clk);
    gate_len = 100; enable = 1'b1;
    @(negedge sys_clk);
    gate_len = 50;
    wait_valid(200, ok);
    chk("ov_timeout", 32'(ok), 1);
    enable = 1'b0;
    chk("ov_first_high0", f32(res_high, 0), 100);
    chk("ov_first_ovr",   32'(res_overrun), 0);
    repeat (60) @(negedge sys_clk);
    chk("ov_ovr",   32'(res_overrun), 1);
    chk("ov_valid", 32'(res_valid), 1);
    chk("ov_high0", f32(res_high, 0), 50);
    chk("ov_low1",  f32(res_low, 1), 50);
    chk("ov_busy",  32'(busy), 0);

    // reset at cycle 50 of a 100-cycle window
    gate_len = 100; enable = 1'b1;
    @(negedge sys_clk);
    enable = 1'b0;
    repeat (49) @(negedge sys_clk);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(res_valid), 0);
    chk("mr_ovr",   32'(res_overrun), 0);
    chk("mr_busy",  32'(busy), 0);
    chk("mr_high0", f32(res_high, 0), 0);
    chk("mr_low1",  f32(res_low, 1), 0);
    chk("mr_sat",   32'(res_sat), 0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    enable = 1'b1;
    @(negedge sys_clk);
    enable = 1'b0;
    wait_valid(200, ok);
    chk("ar_timeout", 32'(ok), 1);
    chk("ar_high0", f32(res_high, 0), 100);
    chk("ar_low1",  f32(res_low, 1), 100);
    chk("ar_ovr",   32'(res_overrun), 0);
    res_ready = 1'b1;
    @(negedge sys_clk);
    res_ready = 1'b0;

`ifdef DUTY_METER_EDGE_CNT_EN
    // ten 3-high/3-low pulses on channel 3 inside a 100-cycle window
    sig_base = 4'b0001;
    repeat (5) @(negedge sys_clk);
    gate_len = 100;
    for (int k = 0; k < 150; k++) begin
      sig_base[3] = (k >= 10) && (k < 70) && (((k - 10) % 6) < 3);
      if (k == 0) enable = 1'b1;
      if (k == 1) enable = 1'b0;
      @(negedge sys_clk);
    end
    chk("ed_valid", 32'(res_valid), 1);
    chk("ed_edges3", f32(res_edges, 3), 10);
    chk("ed_edges0", f32(res_edges, 0), 0);
    chk("ed_high3",  f32(res_high, 3), 30);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
